// File: rtl/rect_paint_arbiter_pkg.sv
// Screen/memory geometry macros, pixel-walk state encoding and PIX_CYC bounds
// shared by rect_paint_arbiter and rect_fill_engine.
`ifndef SCR_WIDTH_BITS
`define SCR_WIDTH_BITS 10
`endif
`ifndef SCR_HEIGHT_BITS
`define SCR_HEIGHT_BITS 9
`endif
`ifndef MEMORY_SIZE_BITS
`define MEMORY_SIZE_BITS 19
`endif
`ifndef MAP_PIXELCO_MEMADDR
// Row-major 640-pixel lines: y*640 + x, with 640 = 512 + 128.
`define MAP_PIXELCO_MEMADDR(x,y) (((y) << 9) + ((y) << 7) + (x))
`endif

package rect_paint_arbiter_pkg;

    localparam int SCR_WIDTH_BITS   = `SCR_WIDTH_BITS;
    localparam int SCR_HEIGHT_BITS  = `SCR_HEIGHT_BITS;
    localparam int MEMORY_SIZE_BITS = `MEMORY_SIZE_BITS;

    localparam int PIX_CYC_MIN = 1;
    localparam int PIX_CYC_MAX = 3;
    localparam int PIX_CNT_W   = $clog2(PIX_CYC_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } fill_state_e;

    function automatic logic [MEMORY_SIZE_BITS-1:0] map_pixel_addr(
        input logic [SCR_WIDTH_BITS-1:0]  x,
        input logic [SCR_HEIGHT_BITS-1:0] y
    );
        logic [MEMORY_SIZE_BITS-1:0] xm;
        logic [MEMORY_SIZE_BITS-1:0] ym;
        xm = MEMORY_SIZE_BITS'(x);
        ym = MEMORY_SIZE_BITS'(y);
        return `MAP_PIXELCO_MEMADDR(xm, ym);
    endfunction

endpackage

// File: rtl/rect_fill_engine.sv
// Pixel-walk datapath: latches one rectangle on start_i and writes it row by
// row, each pixel PIX_CYC strobe cycles followed by one gap cycle.
module rect_fill_engine
    import rect_paint_arbiter_pkg::*;
#(
    parameter int PIX_CYC = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [SCR_WIDTH_BITS-1:0]   x_start_i,
    input  logic [SCR_WIDTH_BITS-1:0]   x_end_i,
    input  logic [SCR_HEIGHT_BITS-1:0]  y_start_i,
    input  logic [SCR_HEIGHT_BITS-1:0]  y_end_i,
    input  logic [2:0]                  color_i,
    output logic                        done_o,
    output logic [MEMORY_SIZE_BITS-1:0] address_o,
    output logic [2:0]                  color_o,
    output logic                        print_enable_o
);

    localparam logic [PIX_CNT_W-1:0] CNT_LAST = PIX_CNT_W'(PIX_CYC - 1);

    fill_state_e                 state_q;
    logic [SCR_WIDTH_BITS-1:0]   xs_q, xe_q, x_q, x_d;
    logic [SCR_HEIGHT_BITS-1:0]  ys_q, ye_q, y_q, y_d;
    logic [PIX_CNT_W-1:0]        cnt_q;
    logic [2:0]                  col_q;
    logic [MEMORY_SIZE_BITS-1:0] addr_q;
    logic                        pe_q, done_q;
    logic                        x_last, y_last;

    // end > start is guaranteed once past LOAD, so end-1 cannot wrap.
    assign x_last = (x_q == xe_q - 1'b1);
    assign y_last = (y_q == ye_q - 1'b1);
    assign x_d    = x_last ? xs_q : x_q + 1'b1;
    assign y_d    = x_last ? y_q + 1'b1 : y_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            xs_q    <= '0;
            xe_q    <= '0;
            ys_q    <= '0;
            ye_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            pe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        xs_q    <= x_start_i;
                        xe_q    <= x_end_i;
                        ys_q    <= y_start_i;
                        ye_q    <= y_end_i;
                        col_q   <= color_i;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    x_q <= xs_q;
                    y_q <= ys_q;
                    if (xe_q <= xs_q || ye_q <= ys_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        addr_q  <= map_pixel_addr(xs_q, ys_q);
                        cnt_q   <= '0;
                        pe_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == CNT_LAST) begin
                        pe_q    <= 1'b0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (x_last && y_last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        addr_q  <= map_pixel_addr(x_d, y_d);
                        cnt_q   <= '0;
                        pe_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done_o         = done_q;
    assign address_o      = addr_q;
    assign color_o        = col_q;
    assign print_enable_o = pe_q;

endmodule

// File: rtl/rect_paint_arbiter.sv
// Arbitrates NREQ rectangle painters onto one video-memory write port.
// Define RECT_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module rect_paint_arbiter
    import rect_paint_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int PIX_CYC = 2
) (
    input  logic                         Clck,
    input  logic                         Reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*SCR_WIDTH_BITS-1:0]  rect_x_start,
    input  logic [NREQ*SCR_WIDTH_BITS-1:0]  rect_x_end,
    input  logic [NREQ*SCR_HEIGHT_BITS-1:0] rect_y_start,
    input  logic [NREQ*SCR_HEIGHT_BITS-1:0] rect_y_end,
    input  logic [NREQ*3-1:0]            rect_color,
    output logic [NREQ-1:0]              grant,
    output logic [NREQ-1:0]              done,
    output logic [MEMORY_SIZE_BITS-1:0]  address,
    output logic [2:0]                   color,
    output logic                         print_enable
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW    = SCR_WIDTH_BITS;
    localparam int SH    = SCR_HEIGHT_BITS;
    // Out-of-range PIX_CYC is clamped to the legal strobe length.
    localparam int PIX_CYC_EFF = (PIX_CYC < PIX_CYC_MIN) ? PIX_CYC_MIN :
                                 (PIX_CYC > PIX_CYC_MAX) ? PIX_CYC_MAX : PIX_CYC;

    logic [NREQ-1:0]  grant_q;
    logic [IDX_W-1:0] win_idx;
    logic             start;
    logic             eng_done;
`ifdef RECT_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q;
`endif

    always_comb begin
        win_idx = '0;
`ifdef RECT_ARB_ROUND_ROBIN_EN
        // Descending scan so the nearest requester after last_q wins.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NREQ]) win_idx = IDX_W'((int'(last_q) + k) % NREQ);
        end
`else
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IDX_W'(i);
        end
`endif
    end

    // A zero grant means the engine is idle and at least one idle cycle passed.
    assign start = (grant_q == '0) && (|req);

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            grant_q <= '0;
`ifdef RECT_ARB_ROUND_ROBIN_EN
            last_q  <= IDX_W'(NREQ - 1);
`endif
        end else if (start) begin
            grant_q <= NREQ'(1) << win_idx;
`ifdef RECT_ARB_ROUND_ROBIN_EN
            last_q  <= win_idx;
`endif
        end else if (eng_done) begin
            grant_q <= '0;
        end
    end

    rect_fill_engine #(
        .PIX_CYC(PIX_CYC_EFF)
    ) u_engine (
        .clk_i          (Clck),
        .rst_ni         (Reset),
        .start_i        (start),
        .x_start_i      (rect_x_start[int'(win_idx)*SW +: SW]),
        .x_end_i        (rect_x_end[int'(win_idx)*SW +: SW]),
        .y_start_i      (rect_y_start[int'(win_idx)*SH +: SH]),
        .y_end_i        (rect_y_end[int'(win_idx)*SH +: SH]),
        .color_i        (rect_color[int'(win_idx)*3 +: 3]),
        .done_o         (eng_done),
        .address_o      (address),
        .color_o        (color),
        .print_enable_o (print_enable)
    );

    assign grant = grant_q;
    assign done  = eng_done ? grant_q : '0;

endmodule

// File: tb/tb_rect_paint_arbiter.sv
// Self-checking bench for rect_paint_arbiter: directed scenarios plus random
// jobs compared against a pixel-list reference model.
module tb_rect_paint_arbiter;
    import rect_paint_arbiter_pkg::*;

    localparam int NREQ    = 3;
    localparam int PIX_CYC = 2;
    localparam int SW = SCR_WIDTH_BITS;
    localparam int SH = SCR_HEIGHT_BITS;
    localparam int MW = MEMORY_SIZE_BITS;

    logic                 Clck = 1'b0;
    logic                 Reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*SW-1:0]   rect_x_start, rect_x_end;
    logic [NREQ*SH-1:0]   rect_y_start, rect_y_end;
    logic [NREQ*3-1:0]    rect_color;
    logic [NREQ-1:0]      grant, done;
    logic [MW-1:0]        address;
    logic [2:0]           color;
    logic                 print_enable;

    int       xs_a[NREQ], xe_a[NREQ], ys_a[NREQ], ye_a[NREQ];
    logic [2:0] col_a[NREQ];
    int       errors = 0;
    int       checks = 0;
    int       last_gnt = NREQ - 1;

    always #5 Clck = ~Clck;

    rect_paint_arbiter #(.NREQ(NREQ), .PIX_CYC(PIX_CYC)) dut (
        .Clck(Clck), .Reset(Reset), .req(req),
        .rect_x_start(rect_x_start), .rect_x_end(rect_x_end),
        .rect_y_start(rect_y_start), .rect_y_end(rect_y_end),
        .rect_color(rect_color), .grant(grant), .done(done),
        .address(address), .color(color), .print_enable(print_enable)
    );

    task automatic step();
        @(posedge Clck);
        #1;
    endtask

    task automatic drive_rects();
        for (int i = 0; i < NREQ; i++) begin
            rect_x_start[i*SW +: SW] = SW'(xs_a[i]);
            rect_x_end[i*SW +: SW]   = SW'(xe_a[i]);
            rect_y_start[i*SH +: SH] = SH'(ys_a[i]);
            rect_y_end[i*SH +: SH]   = SH'(ye_a[i]);
            rect_color[i*3 +: 3]     = col_a[i];
        end
    endtask

    task automatic rand_rect(input int i);
        xs_a[i]  = $urandom_range(1, 900);
        ys_a[i]  = $urandom_range(1, 450);
        xe_a[i]  = ($urandom_range(0, 7) == 0) ? xs_a[i] - 1 : xs_a[i] + $urandom_range(0, 3);
        ye_a[i]  = ys_a[i] + $urandom_range(1, 3);
        col_a[i] = 3'($urandom);
    endtask

    // Scramble every rectangle input and drop the owner's request mid-job.
    task automatic mutate(input int owner);
        for (int i = 0; i < NREQ; i++) rand_rect(i);
        col_a[owner] = ~col_a[owner];
        req = NREQ'($urandom);
        req[owner] = 1'b0;
        drive_rects();
    endtask

    function automatic int exp_winner(input logic [NREQ-1:0] r);
`ifdef RECT_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) if (r[(last_gnt + k) % NREQ]) return (last_gnt + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    // Entered one sample after the granting edge; walks the expected pixel list.
    task automatic check_job(input int owner, input int mut_px, input int abort_px, input string tag);
        int xs, xe, ys, ye, w, h, px, ea;
        logic [2:0] col;
        logic [NREQ-1:0] oh;
        xs = xs_a[owner]; xe = xe_a[owner]; ys = ys_a[owner]; ye = ye_a[owner];
        col = col_a[owner];
        oh = '0;
        oh[owner] = 1'b1;
        last_gnt = owner;
        checks++;
        if (grant !== oh || print_enable !== 1'b0 || done !== '0) begin
            errors++;
            $display("FAIL %s grant: grant=%b pe=%b done=%b, wanted grant=%b pe=0 done=0", tag, grant, print_enable, done, oh);
        end
        step();
        w = (xe > xs) ? xe - xs : 0;
        h = (ye > ys) ? ye - ys : 0;
        if (w == 0) h = 0;
        px = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                ea = (ys + y) * 640 + xs + x;
                for (int c = 0; c < PIX_CYC; c++) begin
                    if (px == mut_px && c == 0) mutate(owner);
                    checks++;
                    if (print_enable !== 1'b1 || address !== MW'(ea) || color !== col || grant !== oh || done !== '0) begin
                        errors++;
                        $display("FAIL %s write px%0d c%0d: pe=%b addr=%0d col=%0d grant=%b done=%b, wanted pe=1 addr=%0d col=%0d grant=%b done=0",
                                 tag, px, c, print_enable, address, color, grant, done, ea, col, oh);
                    end
                    if (px == abort_px && c == 0) return;
                    step();
                end
                checks++;
                if (print_enable !== 1'b0 || address !== MW'(ea) || grant !== oh || done !== '0) begin
                    errors++;
                    $display("FAIL %s gap px%0d: pe=%b addr=%0d grant=%b done=%b, wanted pe=0 addr=%0d grant=%b done=0",
                             tag, px, print_enable, address, grant, done, ea, oh);
                end
                step();
                px++;
            end
        end
        checks++;
        if (done !== oh || grant !== oh || print_enable !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b grant=%b pe=%b, wanted done=%b grant=%b pe=0", tag, done, grant, print_enable, oh, oh);
        end
        step();
        checks++;
        if (grant !== '0 || done !== '0 || print_enable !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: grant=%b done=%b pe=%b, wanted all zero", tag, grant, done, print_enable);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        req = '1;
        step();
        step();
        checks++;
        if (grant !== '0 || done !== '0 || print_enable !== 1'b0 || address !== '0 || color !== '0) begin
            errors++;
            $display("FAIL reset_state: grant=%b done=%b pe=%b addr=%0d col=%0d, wanted all zero", grant, done, print_enable, address, color);
        end
        Reset = 1'b1;
        req = '0;
        last_gnt = NREQ - 1;
        step();
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL reset_idle: grant=%b, wanted 0", grant);
        end
    endtask

    task automatic test_single();
        xs_a[0] = 10; xe_a[0] = 12; ys_a[0] = 20; ye_a[0] = 22; col_a[0] = 3'b110;
        drive_rects();
        req = 3'b001;
        step();
        check_job(0, -1, -1, "single");
        req = '0;
    endtask

    task automatic test_degenerate();
        xs_a[1] = 50; xe_a[1] = 50; ys_a[1] = 5; ye_a[1] = 9; col_a[1] = 3'b011;
        xs_a[2] = 70; xe_a[2] = 74; ys_a[2] = 8; ye_a[2] = 6; col_a[2] = 3'b101;
        drive_rects();
        req = 3'b010;
        step();
        check_job(1, -1, -1, "degen_x");
        req = 3'b100;
        step();
        check_job(2, -1, -1, "degen_y");
        req = '0;
    endtask

    task automatic test_contention();
        int seq[4];
`ifdef RECT_ARB_ROUND_ROBIN_EN
        seq = '{0, 1, 2, 0};
`else
        seq = '{0, 0, 0, 0};
`endif
        Reset = 1'b0;
        req = '0;
        step();
        Reset = 1'b1;
        last_gnt = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            xs_a[i] = 30 * i + 5; xe_a[i] = xs_a[i] + 1 + i % 2; ys_a[i] = 40 + i; ye_a[i] = ys_a[i] + 1;
            col_a[i] = 3'(i + 1);
        end
        drive_rects();
        req = '1;
        for (int j = 0; j < 4; j++) begin
            step();
            check_job(seq[j], -1, -1, "contention");
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        xs_a[2] = 100; xe_a[2] = 103; ys_a[2] = 7; ye_a[2] = 9; col_a[2] = 3'b101;
        drive_rects();
        req = 3'b100;
        step();
        check_job(2, -1, 2, "rst_mid_a");
        Reset = 1'b0;
        step();
        checks++;
        if (print_enable !== 1'b0 || grant !== '0 || done !== '0 || address !== '0 || color !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: pe=%b grant=%b done=%b addr=%0d col=%0d, wanted all zero", print_enable, grant, done, address, color);
        end
        Reset = 1'b1;
        last_gnt = NREQ - 1;
        step();
        check_job(2, -1, -1, "rst_mid_b");
        req = '0;
    endtask

    task automatic test_input_change();
        xs_a[0] = 300; xe_a[0] = 302; ys_a[0] = 200; ye_a[0] = 202; col_a[0] = 3'b011;
        drive_rects();
        req = 3'b001;
        step();
        check_job(0, 1, -1, "input_change");
        req = '0;
    endtask

    task automatic test_back_to_back();
        int owner, mut;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NREQ; i++) rand_rect(i);
            drive_rects();
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            owner = exp_winner(req);
            mut = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            step();
            check_job(owner, mut, -1, "random");
        end
        req = '0;
    endtask

    initial begin
        Reset = 1'b0;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            xs_a[i] = 0; xe_a[i] = 0; ys_a[i] = 0; ye_a[i] = 0; col_a[i] = '0;
        end
        drive_rects();
        step();
        test_reset();
        test_single();
        test_degenerate();
        test_contention();
        test_reset_mid();
        test_input_change();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
